// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter and sequencer for the
// single-port 64-bit Data_Memory. Port 0 is the core load/store path and
// port 1 is a secondary master. Each transaction drives the memory for one
// ISSUE cycle. The completion ack follows in the DONE cycle.
// Optional feature macro: DMEM_ARB_BOUND_CHECK_EN. When it is defined, an
// address >= DEPTH is blocked from the memory and reported with err.
module dmem_arbiter #(
  parameter int AW    = 64,
  parameter int DW    = 64,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          busy,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_write_data,
  input  logic [DW-1:0] mem_read_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state;
  logic          g;         // port owning the current transaction
  logic          last;      // port served most recently (tie-break)
  logic          we_q;
  logic          blk_q;     // current transaction blocked by the bound check
  logic          err_q;

  logic          start;
  logic          nxt_g;
  logic          we_sel;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;
  logic          oob;
  logic          blk;

  // Grant selection: round-robin tie-break in IDLE. DONE only hands over to
  // the other port, because the finishing port still holds req during its ack.
  always_comb begin
    start = 1'b0;
    nxt_g = g;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          start = 1'b1;
          nxt_g = ~last;
        end else if (req0) begin
          start = 1'b1;
          nxt_g = 1'b0;
        end else if (req1) begin
          start = 1'b1;
          nxt_g = 1'b1;
        end
      end
      DONE: begin
        if (g ? req0 : req1) begin
          start = 1'b1;
          nxt_g = ~g;
        end
      end
      default: ;
    endcase
  end

  assign we_sel    = nxt_g ? we1    : we0;
  assign addr_sel  = nxt_g ? addr1  : addr0;
  assign wdata_sel = nxt_g ? wdata1 : wdata0;
  assign oob       = (addr_sel >= AW'(DEPTH));

`ifdef DMEM_ARB_BOUND_CHECK_EN
  assign blk = oob;
`else
  logic unused_oob;
  assign unused_oob = oob;
  assign blk        = 1'b0;
`endif

  assign busy = (state != IDLE);
  assign err  = err_q;

  // Sequencer: latch the granted request on ISSUE entry and pulse the memory
  // strobe for one cycle. Then capture read data and pulse the ack in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      g              <= 1'b0;
      last           <= 1'b1;
      we_q           <= 1'b0;
      blk_q          <= 1'b0;
      err_q          <= 1'b0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rdata          <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      err_q <= 1'b0;
      case (state)
        ISSUE: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (blk_q) begin
            rdata <= '0;
          end else if (!we_q) begin
            rdata <= mem_read_data;
          end
          err_q <= blk_q;
          last  <= g;
          ack0  <= ~g;
          ack1  <= g;
          state <= DONE;
        end
        default: begin
          if (start) begin
            state          <= ISSUE;
            g              <= nxt_g;
            we_q           <= we_sel;
            blk_q          <= blk;
            mem_address    <= addr_sel;
            mem_write_data <= wdata_sel;
            mem_read       <= ~we_sel & ~blk;
            mem_write      <= we_sel & ~blk;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter. Expected completions go into a
// scoreboard queue. A negedge monitor pops and compares them on each ack.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [63:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err, busy;
  logic [63:0] rdata;
  logic        mem_read, mem_write;
  logic [63:0] mem_address, mem_write_data, mem_read_data;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(64), .DW(64), .DEPTH(256)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  // Data_Memory stand-in: acts on the falling edge
  logic [63:0] mem [0:511];
  always @(negedge clk) begin
    if (mem_write) mem[mem_address[8:0]] <= mem_write_data;
    if (mem_read)  mem_read_data <= mem[mem_address[8:0]];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cnt_rd   = 0;
  int cnt_wr   = 0;
  int wr_cyc   = 0;
  logic [63:0] wr_addr, wr_data;

  typedef struct {
    int          port;
    bit          chk_rd;
    logic [63:0] rd;
    logic        err;
  } exp_t;
  exp_t sbq[$];
  exp_t e;
  int ackc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Monitor: strobe counting, exclusivity and scoreboard comparison
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (mem_read) cnt_rd++;
      if (mem_write) begin
        cnt_wr++;
        wr_cyc  = cyc;
        wr_addr = mem_address;
        wr_data = mem_write_data;
      end
      chk("ack_excl", 64'(ack0 & ack1), 64'd0);
      chk("rw_excl", 64'(mem_read & mem_write), 64'd0);
      if (ack0 || ack1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_ack", 64'({ack1, ack0}), 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("ack_port", 64'({ack1, ack0}), (e.port == 1) ? 64'd2 : 64'd1);
          if (e.chk_rd) chk("rdata", rdata, e.rd);
          chk("err", 64'(err), 64'(e.err));
        end
      end
    end
  end

  task automatic push(input int port, input bit chk_rd, input logic [63:0] rd, input logic er);
    exp_t x;
    x.port = port; x.chk_rd = chk_rd; x.rd = rd; x.err = er;
    sbq.push_back(x);
  endtask

  // Holds the requests until each port has seen its expected number of acks.
  // Each req is dropped one cycle after its final ack.
  task automatic serve(input int r0, input int r1, input string tag);
    int rem0, rem1, k;
    bit a0, a1;
    rem0 = r0; rem1 = r1; k = 0;
    ackc.delete();
    while ((rem0 > 0 || rem1 > 0) && k < 40) begin
      @(negedge clk);
      a0 = ack0; a1 = ack1;
      if (a0) begin rem0--; ackc.push_back(cyc); end
      if (a1) begin rem1--; ackc.push_back(cyc); end
      @(posedge clk); #1;
      if (a0 && rem0 == 0) req0 = 1'b0;
      if (a1 && rem1 == 0) req1 = 1'b0;
      k++;
    end
    chk({tag, "_done"}, 64'(rem0 + rem1), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ack0"}, 64'(ack0), 64'd0);
    chk({tag, "_ack1"}, 64'(ack1), 64'd0);
    chk({tag, "_rdata"}, rdata, 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_mrd"}, 64'(mem_read), 64'd0);
    chk({tag, "_mwr"}, 64'(mem_write), 64'd0);
    chk({tag, "_maddr"}, mem_address, 64'd0);
    chk({tag, "_mwdata"}, mem_write_data, 64'd0);
  endtask

  int c0, rd0, wr0;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 64'd0;
    mem_read_data = 64'd0;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 64'd0; addr1 = 64'd0; wdata0 = 64'd0; wdata1 = 64'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset("rst");

    // Write 0xDEADBEEF to word 5 from port 0
    @(posedge clk); #1;
    c0 = cyc; wr0 = cnt_wr;
    req0 = 1'b1; we0 = 1'b1; addr0 = 64'd5; wdata0 = 64'hDEAD_BEEF;
    push(0, 1'b0, 64'd0, 1'b0);
    serve(1, 0, "wr5");
    chk("wr5_pulses", 64'(cnt_wr - wr0), 64'd1);
    chk("wr5_addr", wr_addr, 64'd5);
    chk("wr5_data", wr_data, 64'hDEAD_BEEF);
    chk("wr5_issue_cyc", 64'(wr_cyc - c0), 64'd1);
    chk("wr5_ack_lat", 64'(ackc[0] - c0), 64'd2);

    // Read it back from port 0
    rd0 = cnt_rd;
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd5;
    push(0, 1'b1, 64'hDEAD_BEEF, 1'b0);
    serve(1, 0, "rd5");
    chk("rd5_pulses", 64'(cnt_rd - rd0), 64'd1);

    // Contention from reset: grants 0,1,0,1 with no idle gap
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'd6;
    push(0, 1'b1, 64'hDEAD_BEEF, 1'b0);
    push(1, 1'b1, 64'd0, 1'b0);
    push(0, 1'b1, 64'hDEAD_BEEF, 1'b0);
    push(1, 1'b1, 64'd0, 1'b0);
    serve(2, 2, "rr");
    chk("rr_nacks", 64'(ackc.size()), 64'd4);
    for (int i = 1; i < ackc.size(); i++) chk("rr_gap", 64'(ackc[i] - ackc[i-1]), 64'd2);

    // Same-cycle read of 7 by port 0 and write of 7 by port 1
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd7;
    req1 = 1'b1; we1 = 1'b1; addr1 = 64'd7; wdata1 = 64'd1;
    push(0, 1'b1, 64'd0, 1'b0);
    push(1, 1'b0, 64'd0, 1'b0);
    serve(1, 1, "rw7");
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'd7;
    push(1, 1'b1, 64'd1, 1'b0);
    serve(0, 1, "rd7");

    // Reset pulsed while a read is in ISSUE
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd5;
    @(posedge clk); #1;
    chk("abort_busy", 64'(busy), 64'd1);
    chk("abort_mrd", 64'(mem_read), 64'd1);
    reset = 1'b1; req0 = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_reset("abort");
    repeat (3) begin
      @(negedge clk);
      chk("abort_noack", 64'({ack1, ack0}), 64'd0);
    end

    // Out-of-range read after a read that leaves rdata non-zero
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd5;
    push(0, 1'b1, 64'hDEAD_BEEF, 1'b0);
    serve(1, 0, "rd5b");
    rd0 = cnt_rd; wr0 = cnt_wr;
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'd300;
`ifdef DMEM_ARB_BOUND_CHECK_EN
    push(1, 1'b1, 64'd0, 1'b1);
    serve(0, 1, "oob");
    chk("oob_rd_pulses", 64'(cnt_rd - rd0), 64'd0);
`else
    push(1, 1'b1, 64'd0, 1'b0);
    serve(0, 1, "oob");
    chk("oob_rd_pulses", 64'(cnt_rd - rd0), 64'd1);
`endif
    chk("oob_wr_pulses", 64'(cnt_wr - wr0), 64'd0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
